csr_seq: RTL and testbench
==========================

# csr_seq

Commit-side sequencer for the control-status register file. It sits between the ROB head and the CSR block, and decides each cycle whether the head instruction retires normally, issues a CSR access, takes a trap/interrupt, or executes an xRET. It then drives the CSR block's request, trap and return inputs, and turns the result into a PC redirect with a pipeline-flush quiet window.

## Interface
Parameters:
- FLUSH_WAIT, 2: cycles after a redirect during which the head is ignored (range 1–15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- hd_vld  in  1  ROB head valid
- hd_kind  in  2  00 normal, 01 CSR op, 10 exception, 11 xRET
- hd_pc  in  64  head PC
- hd_inst  in  32  head instruction bits (tval for illegal-instruction)
- hd_func / hd_addr / hd_wdat  in  3/12/64  CSR funct3, address, write operand
- hd_cause / hd_tval  in  64/64  exception cause and trap value (kind 10)
- hd_ret  in  2  xRET level: 11 MRET, 01 SRET; others illegal
- hd_ack  out  1  head retired this cycle
- wb_vld / wb_dat  out  1/64  CSR read-data writeback
- redir_vld / redir_pc  out  1/64  redirect plus full pipeline flush
- busy  out  1  state ≠ IDLE
- c_rqst / c_func / c_addr / c_wdat  out  1/3/12/64  CSR request
- c_rdat, c_eout, c_flush  in  64/1/1  CSR response (combinational, same cycle)
- c_ein / c_epc / c_tval / c_cause  out  1/64/64/64  trap entry
- c_ret  out  3  {valid, level}
- c_intr  in  7  {pending, code}
- c_tvec / c_mepc / c_sepc  in  64  trap vector and return PCs

## Operation
- States: IDLE, TRAP, REDIR, QUIET.
- IDLE, evaluated in priority order with hd_vld=1:
  1. c_intr[6]=1: c_ein=1, c_cause={1'b1,57'b0,c_intr[5:0]}, c_epc=hd_pc, c_tval=0. Capture c_tvec into tgt. No ack. Go to REDIR.
  2. kind 10: c_ein=1 with hd_cause/hd_tval and c_epc=hd_pc. Capture c_tvec. No ack. Go to REDIR.
  3. kind 01: c_rqst=1, c_func/c_addr/c_wdat taken from the head.
     - c_eout=1: no ack; latch pc/inst; go to TRAP.
     - Otherwise: hd_ack=1, wb_vld=1, wb_dat=c_rdat.
     - If also c_flush=1: tgt=hd_pc+4 (64-bit wrap), go to REDIR; else stay in IDLE.
  4. kind 11, hd_ret ∈ {11,01}: c_ret={1,hd_ret}, hd_ack=1. tgt=c_mepc for 11, c_sepc for 01, sampled the same cycle as c_ret. Go to REDIR.
     - Any other hd_ret: treat as illegal and go to TRAP with no ack.
  5. kind 00: hd_ack=1, stay in IDLE.
- TRAP (one cycle):
  - c_ein=1, c_cause=2, c_epc=latched pc, c_tval=zero-extended latched inst.
  - Capture c_tvec into tgt. Go to REDIR.
- REDIR (one cycle): redir_vld=1, redir_pc=tgt. Load cnt=FLUSH_WAIT-1. Go to QUIET.
- QUIET: head ignored, all c_* strobes 0. When cnt==0, go to IDLE; otherwise decrement cnt.
- c_intr is sampled only in IDLE. An interrupt pending during TRAP/REDIR/QUIET is taken on the first IDLE cycle with hd_vld=1.
- Idle strobes: c_rqst, c_ein and c_ret[2] are mutually exclusive, and all three are 0 whenever hd_vld=0.

## Timing
- rst_n low (any time, including mid-sequence): state=IDLE, tgt=0, cnt=0, latched pc/inst=0, redir_vld=0.
  - Outputs are combinational from state, so every output is 0 while in reset.
- Normal, CSR and xRET acks are zero-latency: hd_ack is combinational in the cycle the head is presented.
- Redirect latency:
  - 1 cycle after the deciding IDLE cycle for interrupt, exception, CSR-flush and xRET.
  - 2 cycles for a CSR fault (IDLE→TRAP→REDIR).
- Head-to-head spacing after a redirect: the next head is accepted FLUSH_WAIT+1 cycles after the REDIR cycle.
- c_tvec, c_mepc and c_sepc are sampled in the same cycle as the c_ein or c_ret strobe, i.e. before the CSR block's level changes at the clock edge.
- CSR read and write happen in one cycle: the CSR block writes at the edge ending the c_rqst cycle. It does not write if c_eout=1.

## Test plan
- Normal retire: hd_vld=1, kind 00 for 5 cycles → hd_ack high all 5 cycles; no strobes; busy=0.
- CSR read: kind 01, addr 0x340, func 010, wdat 0, c_rdat=0x1234 → same cycle c_rqst=1, wb_dat=0x1234, hd_ack=1; no redirect.
- CSR fault then trap: kind 01, c_eout=1, pc=0x8000_0010, inst=0xC0001073 → next cycle c_ein=1, c_cause=2, c_tval=0xC0001073, c_epc=0x8000_0010. c_tvec=0x8000_0100 → redir_pc=0x8000_0100 the following cycle.
- Interrupt beats CSR: kind 01 with c_intr=7'h47 → c_rqst=0, c_ein=1, c_cause=0x8000_0000_0000_0007. Redirect follows. With FLUSH_WAIT=2, the head is ignored for 2 cycles, then c_rqst=1 on the third.
- MRET: kind 11, hd_ret=11, c_mepc=0x8000_0200 → c_ret=3'b111, hd_ack=1, then redir_pc=0x8000_0200. hd_ret=10 → illegal-instruction trap via TRAP.
- Reset mid-REDIR: drop rst_n asynchronously → redir_vld falls immediately. After release, state is IDLE and a normal head acks on the first valid cycle.

Source files
------------

// File: rtl/csr_seq.sv
// Commit-side CSR sequencer: arbitrates the ROB head between retire, CSR access,
// trap/interrupt entry and xRET, then issues a PC redirect followed by a quiet window.
module csr_seq #(
    parameter int unsigned FLUSH_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hd_vld,
    input  logic [1:0]  hd_kind,
    input  logic [63:0] hd_pc,
    input  logic [31:0] hd_inst,
    input  logic [2:0]  hd_func,
    input  logic [11:0] hd_addr,
    input  logic [63:0] hd_wdat,
    input  logic [63:0] hd_cause,
    input  logic [63:0] hd_tval,
    input  logic [1:0]  hd_ret,
    output logic        hd_ack,
    output logic        wb_vld,
    output logic [63:0] wb_dat,
    output logic        redir_vld,
    output logic [63:0] redir_pc,
    output logic        busy,
    output logic        c_rqst,
    output logic [2:0]  c_func,
    output logic [11:0] c_addr,
    output logic [63:0] c_wdat,
    input  logic [63:0] c_rdat,
    input  logic        c_eout,
    input  logic        c_flush,
    output logic        c_ein,
    output logic [63:0] c_epc,
    output logic [63:0] c_tval,
    output logic [63:0] c_cause,
    output logic [2:0]  c_ret,
    input  logic [6:0]  c_intr,
    input  logic [63:0] c_tvec,
    input  logic [63:0] c_mepc,
    input  logic [63:0] c_sepc
);

    typedef enum logic [1:0] {IDLE, TRAP, REDIR, QUIET} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_WAIT - 1);

    state_t      state, state_nxt;
    logic [63:0] tgt, tgt_nxt;
    logic [63:0] lpc, lpc_nxt;
    logic [31:0] linst, linst_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt   <= '0;
            lpc   <= '0;
            linst <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
            lpc   <= lpc_nxt;
            linst <= linst_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // rst_n gates the head so IDLE's input-driven outputs are also quiet in reset
    assign head = rst_n && hd_vld;
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        lpc_nxt   = lpc;
        linst_nxt = linst;
        cnt_nxt   = cnt;
        hd_ack    = 1'b0;
        wb_vld    = 1'b0;
        wb_dat    = '0;
        redir_vld = 1'b0;
        redir_pc  = '0;
        c_rqst    = 1'b0;
        c_func    = '0;
        c_addr    = '0;
        c_wdat    = '0;
        c_ein     = 1'b0;
        c_epc     = '0;
        c_tval    = '0;
        c_cause   = '0;
        c_ret     = '0;

        unique case (state)
            IDLE: begin
                if (head) begin
                    if (c_intr[6]) begin
                        c_ein     = 1'b1;
                        c_cause   = {1'b1, 57'b0, c_intr[5:0]};
                        c_epc     = hd_pc;
                        tgt_nxt   = c_tvec;
                        state_nxt = REDIR;
                    end else begin
                        unique case (hd_kind)
                            2'b10: begin
                                c_ein     = 1'b1;
                                c_cause   = hd_cause;
                                c_tval    = hd_tval;
                                c_epc     = hd_pc;
                                tgt_nxt   = c_tvec;
                                state_nxt = REDIR;
                            end
                            2'b01: begin
                                c_rqst = 1'b1;
                                c_func = hd_func;
                                c_addr = hd_addr;
                                c_wdat = hd_wdat;
                                if (c_eout) begin
                                    lpc_nxt   = hd_pc;
                                    linst_nxt = hd_inst;
                                    state_nxt = TRAP;
                                end else begin
                                    hd_ack = 1'b1;
                                    wb_vld = 1'b1;
                                    wb_dat = c_rdat;
                                    if (c_flush) begin
                                        tgt_nxt   = hd_pc + 64'd4;
                                        state_nxt = REDIR;
                                    end
                                end
                            end
                            2'b11: begin
                                if (hd_ret == 2'b11 || hd_ret == 2'b01) begin
                                    c_ret     = {1'b1, hd_ret};
                                    hd_ack    = 1'b1;
                                    tgt_nxt   = (hd_ret == 2'b11) ? c_mepc : c_sepc;
                                    state_nxt = REDIR;
                                end else begin
                                    lpc_nxt   = hd_pc;
                                    linst_nxt = hd_inst;
                                    state_nxt = TRAP;
                                end
                            end
                            default: hd_ack = 1'b1;
                        endcase
                    end
                end
            end
            TRAP: begin
                // illegal instruction: cause 2, tval carries the faulting encoding
                c_ein     = 1'b1;
                c_cause   = 64'd2;
                c_epc     = lpc;
                c_tval    = {32'b0, linst};
                tgt_nxt   = c_tvec;
                state_nxt = REDIR;
            end
            REDIR: begin
                redir_vld = 1'b1;
                redir_pc  = tgt;
                cnt_nxt   = CNT_LOAD;
                state_nxt = QUIET;
            end
            QUIET: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_seq.sv
// Scoreboard bench for csr_seq: a cycle-scheduled reference model pushes expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_csr_seq;

    localparam int unsigned FW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hd_vld;
    logic [1:0]  hd_kind;
    logic [63:0] hd_pc;
    logic [31:0] hd_inst;
    logic [2:0]  hd_func;
    logic [11:0] hd_addr;
    logic [63:0] hd_wdat, hd_cause, hd_tval;
    logic [1:0]  hd_ret;
    logic        hd_ack, wb_vld, redir_vld, busy, c_rqst, c_ein;
    logic [63:0] wb_dat, redir_pc, c_wdat, c_epc, c_tval, c_cause;
    logic [2:0]  c_func, c_ret;
    logic [11:0] c_addr;
    logic [63:0] c_rdat, c_tvec, c_mepc, c_sepc;
    logic        c_eout, c_flush;
    logic [6:0]  c_intr;

    csr_seq #(.FLUSH_WAIT(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .hd_vld(hd_vld), .hd_kind(hd_kind), .hd_pc(hd_pc), .hd_inst(hd_inst),
        .hd_func(hd_func), .hd_addr(hd_addr), .hd_wdat(hd_wdat),
        .hd_cause(hd_cause), .hd_tval(hd_tval), .hd_ret(hd_ret),
        .hd_ack(hd_ack), .wb_vld(wb_vld), .wb_dat(wb_dat),
        .redir_vld(redir_vld), .redir_pc(redir_pc), .busy(busy),
        .c_rqst(c_rqst), .c_func(c_func), .c_addr(c_addr), .c_wdat(c_wdat),
        .c_rdat(c_rdat), .c_eout(c_eout), .c_flush(c_flush),
        .c_ein(c_ein), .c_epc(c_epc), .c_tval(c_tval), .c_cause(c_cause),
        .c_ret(c_ret), .c_intr(c_intr),
        .c_tvec(c_tvec), .c_mepc(c_mepc), .c_sepc(c_sepc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        wb_vld;
        logic [63:0] wb_dat;
        logic        redir_vld;
        logic [63:0] redir_pc;
        logic        busy;
        logic        rqst;
        logic [2:0]  func;
        logic [11:0] addr;
        logic [63:0] wdat;
        logic        ein;
        logic [63:0] epc, tval, cause;
        logic [2:0]  ret;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model keeps absolute cycle numbers for scheduled trap entry / redirect,
    // and the first cycle the head is looked at again.
    int          n = 0;
    int          trap_cyc = -1, redir_cyc = -1, free_cyc = 0;
    logic [63:0] m_tgt = '0, m_lpc = '0;
    logic [31:0] m_linst = '0;

    // reset-mid-redirect snapshots, checked by the monitor
    int          mid_seq = 0;
    logic        mid_pre_v, mid_post_v, mid_post_busy, mid_post_ack;
    logic [63:0] mid_pre_pc;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc@%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    function automatic void redirect_at(input int c);
        redir_cyc = c;
        free_cyc  = c + int'(FW) + 1;
    endfunction

    task automatic apply();
        exp_t e;
        e = '{default: '0};
        if (!rst_n) begin
            trap_cyc = -1; redir_cyc = -1; free_cyc = 0;
            m_tgt = '0; m_lpc = '0; m_linst = '0;
        end else begin
            e.busy = (n < free_cyc);
            if (n == trap_cyc) begin
                e.ein = 1'b1; e.cause = 64'd2; e.epc = m_lpc; e.tval = {32'b0, m_linst};
                m_tgt = c_tvec;
            end else if (n == redir_cyc) begin
                e.redir_vld = 1'b1; e.redir_pc = m_tgt;
            end else if (n >= free_cyc && hd_vld) begin
                if (c_intr[6]) begin
                    e.ein = 1'b1; e.cause = {1'b1, 57'b0, c_intr[5:0]}; e.epc = hd_pc;
                    m_tgt = c_tvec; redirect_at(n + 1);
                end else if (hd_kind == 2'b10) begin
                    e.ein = 1'b1; e.cause = hd_cause; e.tval = hd_tval; e.epc = hd_pc;
                    m_tgt = c_tvec; redirect_at(n + 1);
                end else if (hd_kind == 2'b01) begin
                    e.rqst = 1'b1; e.func = hd_func; e.addr = hd_addr; e.wdat = hd_wdat;
                    if (c_eout) begin
                        m_lpc = hd_pc; m_linst = hd_inst; trap_cyc = n + 1; redirect_at(n + 2);
                    end else begin
                        e.ack = 1'b1; e.wb_vld = 1'b1; e.wb_dat = c_rdat;
                        if (c_flush) begin
                            m_tgt = hd_pc + 64'd4; redirect_at(n + 1);
                        end
                    end
                end else if (hd_kind == 2'b11) begin
                    if (hd_ret == 2'b11 || hd_ret == 2'b01) begin
                        e.ret = {1'b1, hd_ret}; e.ack = 1'b1;
                        m_tgt = (hd_ret == 2'b11) ? c_mepc : c_sepc;
                        redirect_at(n + 1);
                    end else begin
                        m_lpc = hd_pc; m_linst = hd_inst; trap_cyc = n + 1; redirect_at(n + 2);
                    end
                end else begin
                    e.ack = 1'b1;
                end
            end
        end
        q.push_back(e);
        n++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hd_vld = 0; hd_kind = 0; hd_pc = 0; hd_inst = 0; hd_func = 0; hd_addr = 0;
        hd_wdat = 0; hd_cause = 0; hd_tval = 0; hd_ret = 0;
        c_rdat = 0; c_eout = 0; c_flush = 0; c_intr = 0; c_tvec = 0; c_mepc = 0; c_sepc = 0;
    endtask

    task automatic randomize_inputs();
        hd_vld   = ($urandom_range(0, 9) < 8);
        hd_kind  = 2'($urandom_range(0, 3));
        hd_pc    = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom(), $urandom()};
        hd_inst  = $urandom();
        hd_func  = 3'($urandom_range(0, 7));
        hd_addr  = 12'($urandom_range(0, 4095));
        hd_wdat  = {$urandom(), $urandom()};
        hd_cause = {$urandom(), $urandom()};
        hd_tval  = {$urandom(), $urandom()};
        hd_ret   = 2'($urandom_range(0, 3));
        c_rdat   = {$urandom(), $urandom()};
        c_eout   = ($urandom_range(0, 4) == 0);
        c_flush  = ($urandom_range(0, 3) == 0);
        c_intr   = {($urandom_range(0, 9) == 0), 6'($urandom_range(0, 63))};
        c_tvec   = {$urandom(), $urandom()};
        c_mepc   = {$urandom(), $urandom()};
        c_sepc   = {$urandom(), $urandom()};
    endtask

    int mid_done = 0;
    always @(negedge clk) begin
        if (mid_seq != mid_done) begin
            mid_done = mid_seq;
            chk("mid_redir_pre", {mid_pre_v, mid_pre_pc}, {1'b1, 64'hABCD});
            chk("mid_redir_rst", {62'b0, mid_post_v, mid_post_busy, mid_post_ack}, '0);
        end
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ack",   {64'b0, hd_ack},                         {64'b0, e.ack});
            chk("wb",    {wb_vld, wb_dat},                        {e.wb_vld, e.wb_dat});
            chk("redir", {redir_vld, redir_pc},                   {e.redir_vld, e.redir_pc});
            chk("busy",  {64'b0, busy},                           {64'b0, e.busy});
            chk("rqst",  {49'b0, c_rqst, c_func, c_addr},         {49'b0, e.rqst, e.func, e.addr});
            chk("wdat",  {1'b0, c_wdat},                          {1'b0, e.wdat});
            chk("ein",   {c_ein, c_cause},                        {e.ein, e.cause});
            chk("epc",   {1'b0, c_epc},                           {1'b0, e.epc});
            chk("tval",  {1'b0, c_tval},                          {1'b0, e.tval});
            chk("ret",   {62'b0, c_ret},                          {62'b0, e.ret});
        end
    end

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) begin
            tick(); clr(); hd_vld = 1; apply();
        end
        tick(); rst_n = 1'b1;
        repeat (5) begin
            clr(); hd_vld = 1; apply(); tick();
        end
        // CSR read
        clr(); hd_vld = 1; hd_kind = 2'b01; hd_addr = 12'h340; hd_func = 3'b010;
        c_rdat = 64'h1234; apply();
        // CSR fault, then illegal-instruction trap
        tick(); clr(); hd_vld = 1; hd_kind = 2'b01; c_eout = 1;
        hd_pc = 64'h8000_0010; hd_inst = 32'hC000_1073; apply();
        tick(); clr(); hd_vld = 1; c_tvec = 64'h8000_0100; apply();
        repeat (4) begin
            tick(); clr(); hd_vld = 1; apply();
        end
        // interrupt beats CSR
        tick(); clr(); hd_vld = 1; hd_kind = 2'b01; c_intr = 7'h47; c_tvec = 64'h8000_0300; apply();
        repeat (4) begin
            tick(); clr(); hd_vld = 1; hd_kind = 2'b01; c_rdat = 64'h55; apply();
        end
        // MRET
        tick(); clr(); hd_vld = 1; hd_kind = 2'b11; hd_ret = 2'b11; c_mepc = 64'h8000_0200; apply();
        repeat (4) begin
            tick(); clr(); hd_vld = 1; apply();
        end
        // illegal xRET level
        tick(); clr(); hd_vld = 1; hd_kind = 2'b11; hd_ret = 2'b10;
        hd_pc = 64'h8000_0040; hd_inst = 32'h3020_0073; apply();
        repeat (5) begin
            tick(); clr(); hd_vld = 1; c_tvec = 64'h8000_0100; apply();
        end
        // CSR flush at top of address space wraps
        tick(); clr(); hd_vld = 1; hd_kind = 2'b01; c_flush = 1; hd_pc = 64'hFFFF_FFFF_FFFF_FFFC; apply();
        repeat (4) begin
            tick(); clr(); hd_vld = 1; apply();
        end
        // reset asserted during the REDIR cycle
        tick(); clr(); hd_vld = 1; hd_kind = 2'b10; hd_cause = 64'd5; c_tvec = 64'hABCD; apply();
        tick(); clr(); hd_vld = 1;
        #1;
        mid_pre_v = redir_vld; mid_pre_pc = redir_pc;
        rst_n = 1'b0;
        #1;
        mid_post_v = redir_vld; mid_post_busy = busy; mid_post_ack = hd_ack;
        mid_seq++;
        apply();
        tick(); clr(); hd_vld = 1; apply();
        tick(); rst_n = 1'b1; clr(); hd_vld = 1; apply();
        // randomized traffic
        repeat (3000) begin
            tick(); randomize_inputs(); apply();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
